decoder_round_sequencer: RTL



---
 rtl/decoder_round_sequencer_pkg.sv | 39 +++
 rtl/decoder_round_sequencer_fifo.sv | 69 ++++++
 rtl/decoder_round_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/decoder_round_sequencer_pkg.sv
// Shared definitions for the decoder round sequencer.
//   - STAGE_* encodings / STAGE_WIDTH as driven by decoder_stage_controller
//   - RESULT_STATUS_* codes carried in each result record
//   - result_rec_t: packed record layout for the default widths
//   - seq_state_e: round sequencer FSM states
package decoder_round_sequencer_pkg;

  localparam int STAGE_WIDTH = 3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE   = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_LOAD   = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_SPREAD = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE  = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEEL   = 3'd4;

  localparam logic [1:0] RESULT_STATUS_OK       = 2'b00;
  localparam logic [1:0] RESULT_STATUS_DEADLOCK = 2'b01;
  localparam logic [1:0] RESULT_STATUS_TIMEOUT  = 2'b10;

  localparam int REC_ROUND_ID_W = 16;
  localparam int REC_ITER_W     = 8;

  // Field order matches the concatenation the sequencer pushes into the FIFO.
  typedef struct packed {
    logic [REC_ROUND_ID_W-1:0] round_id;
    logic [1:0]                status;
    logic                      final_cardinality;
    logic [REC_ITER_W-1:0]     iterations;
    logic [31:0]               cycles;
  } result_rec_t;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_START,
    SEQ_WAIT_LOAD,
    SEQ_RUN,
    SEQ_CAPTURE
  } seq_state_e;

endpackage

// File: rtl/decoder_round_sequencer_fifo.sv
// decoder_result_fifo: synchronous first-word-fall-through FIFO of records.
//   clk, reset_n        : clock, async active-low reset (empties the FIFO)
//   push, push_data     : write one record (ignored when full)
//   pop                 : remove head (ignored when empty)
//   head_data           : current head, forced to 0 while empty
//   head_valid          : FIFO non-empty
//   count               : number of stored records
module decoder_result_fifo #(
  parameter int DATA_W = 59,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid,
  output logic [CW-1:0]     count
);

  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (count_q != DEPTH_CNT);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;  // DEPTH is a power of two: natural wrap
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/decoder_round_sequencer.sv
// decoder_round_sequencer: takes host decode requests, pulses new_round_start
// to the stage controller, follows the round to completion and stores the
// outcome in a result FIFO drained by the host over valid/ready.
//   round_request / round_accept      : host request, one-cycle accept pulse
//   new_round_start                   : one-cycle start pulse to the controller
//   stage, result_valid, deadlock,
//   final_cardinality, iteration_counter, cycle_counter : controller status
//   out_valid / out_ready / out_*     : FWFT result FIFO head
//   fifo_count                        : stored records
//   busy                              : FSM not in IDLE
// Build option: DECODER_ROUND_WATCHDOG_EN adds a RUN-state watchdog that ends
// a stuck round with TIMEOUT status after ROUND_TIMEOUT cycles.
module decoder_round_sequencer
  import decoder_round_sequencer_pkg::*;
#(
  parameter int ITERATION_COUNTER_WIDTH = REC_ITER_W,
  parameter int FIFO_DEPTH              = 4,
  parameter int ROUND_ID_WIDTH          = REC_ROUND_ID_W,
  parameter int ROUND_TIMEOUT           = 4096,
  localparam int CW                     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               round_request,
  output logic                               round_accept,
  output logic                               new_round_start,
  input  logic [STAGE_WIDTH-1:0]             stage,
  input  logic                               result_valid,
  input  logic                               deadlock,
  input  logic                               final_cardinality,
  input  logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
  input  logic [31:0]                        cycle_counter,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [ROUND_ID_WIDTH-1:0]          out_round_id,
  output logic [1:0]                         out_status,
  output logic                               out_final_cardinality,
  output logic [ITERATION_COUNTER_WIDTH-1:0] out_iterations,
  output logic [31:0]                        out_cycles,
  output logic [CW-1:0]                      fifo_count,
  output logic                               busy
);

  localparam int REC_W = ROUND_ID_WIDTH + 2 + 1 + ITERATION_COUNTER_WIDTH + 32;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  seq_state_e                state_q, state_d;
  logic [ROUND_ID_WIDTH-1:0] round_id_q, round_id_d;
  logic [1:0]                status_q, status_d;
  logic                      push;
  logic [REC_W-1:0]          push_rec, head_rec;
  logic                      stage_idle;

  assign stage_idle = (stage == STAGE_IDLE);

`ifdef DECODER_ROUND_WATCHDOG_EN
  localparam int WD_W = $clog2(ROUND_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(ROUND_TIMEOUT);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_expired;

  assign wd_expired = (wd_q == WD_LIMIT);

  // Cleared on START, counts RUN cycles, holds at the limit.
  always_comb begin
    wd_d = wd_q;
    if (state_q == SEQ_START)                   wd_d = '0;
    else if (state_q == SEQ_RUN && !wd_expired) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wd_q <= '0;
    else          wd_q <= wd_d;
  end
`endif

  always_comb begin
    state_d         = state_q;
    round_id_d      = round_id_q;
    status_d        = status_q;
    round_accept    = 1'b0;
    new_round_start = 1'b0;
    push            = 1'b0;
    case (state_q)
      // Reserving a FIFO slot here means CAPTURE can never hit a full FIFO.
      SEQ_IDLE: if (round_request && fifo_count != FULL_CNT) state_d = SEQ_START;
      SEQ_START: begin
        round_accept    = 1'b1;
        new_round_start = 1'b1;
        state_d         = SEQ_WAIT_LOAD;
      end
      SEQ_WAIT_LOAD: if (!stage_idle) state_d = SEQ_RUN;
      SEQ_RUN: begin
        if (stage_idle && result_valid) begin
          status_d = RESULT_STATUS_OK;
          state_d  = SEQ_CAPTURE;
        end else if (stage_idle && deadlock) begin
          status_d = RESULT_STATUS_DEADLOCK;
          state_d  = SEQ_CAPTURE;
        end
`ifdef DECODER_ROUND_WATCHDOG_EN
        else if (wd_expired) begin
          status_d = RESULT_STATUS_TIMEOUT;
          state_d  = SEQ_CAPTURE;
        end
`endif
      end
      SEQ_CAPTURE: begin
        push       = 1'b1;
        round_id_d = round_id_q + 1'b1;
        state_d    = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SEQ_IDLE;
      round_id_q <= '0;
      status_q   <= RESULT_STATUS_OK;
    end else begin
      state_q    <= state_d;
      round_id_q <= round_id_d;
      status_q   <= status_d;
    end
  end

  // Controller result fields are taken live in CAPTURE; status was latched in RUN.
  assign push_rec = {round_id_q, status_q, final_cardinality, iteration_counter, cycle_counter};

  decoder_result_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_data  (push_rec),
    .pop        (out_ready),
    .head_data  (head_rec),
    .head_valid (out_valid),
    .count      (fifo_count)
  );

  assign {out_round_id, out_status, out_final_cardinality, out_iterations, out_cycles} = head_rec;
  assign busy = (state_q != SEQ_IDLE);

endmodule
